// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - per-register stage scoreboard driving ID freeze and EXE forwarding selectors
//
// Purpose:
//   Tracks every in-flight register write by pipeline stage (0=EXE, 1..MEM_LAT=MEMk,
//   MEM_LAT+1=WB) and decides, for the instruction in ID, whether it must freeze or
//   which stage result each of its operands should be forwarded from in EXE.
//
// Parameters:
//   REG_ADDR_W  register address width (2**REG_ADDR_W registers, r0 reads as zero)
//   MEM_LAT     number of MEM stages, 1..4
//   SEL_W       forwarding selector width
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   en_fwd                1 = forwarding, 0 = stall-only
//   flush                 kills the instructions in ID and EXE this cycle
//   id_*                  decoded fields of the instruction in ID
//   hazard_detected       combinational freeze for PC and IF/ID
//   val1_selector         registered forwarding source for EXE operand 1
//   val2_selector         registered forwarding source for EXE ALU operand 2
//   src2_val_selector     registered forwarding source for EXE store data
//   stall_cycles          (HAZARD_PERF_CNT_EN only) saturating count of freeze cycles
//   load_use_stalls       (HAZARD_PERF_CNT_EN only) saturating count of load-use freezes
//
// Optional feature macro: HAZARD_PERF_CNT_EN

module scoreboard_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int SEL_W      = $clog2(MEM_LAT + 2)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_fwd,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_regs,
    input  logic                  id_src2_st,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    output logic                  hazard_detected,
    output logic [SEL_W-1:0]      val1_selector,
    output logic [SEL_W-1:0]      val2_selector,
    output logic [SEL_W-1:0]      src2_val_selector
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           load_use_stalls
`endif
);

    localparam int NREG = 1 << REG_ADDR_W;
    localparam int NST  = MEM_LAT + 2;

    // One bit per stage per register: bit j set = a writer of that register is at stage j.
    logic [NREG-1:0][NST-1:0] pend_q, pend_d;
    logic [NREG-1:0][NST-1:0] load_q, load_d;

    logic [SEL_W-1:0] val1_q, val1_d;
    logic [SEL_W-1:0] val2_q, val2_d;
    logic [SEL_W-1:0] sv_q, sv_d;

    logic             rel1, rel2;
    logic             hit1, hit2;
    logic             ld1, ld2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             stall1, stall2;
    logic             issue;

    // Finds the youngest writer among EXE..MEMn and reports {hit, load_stall, selector}.
    // Scanning from the oldest stage down lets the youngest (lowest index) overwrite.
    // The WB bit is never consulted: the register file writes before it is read.
    // A load only stalls while it has not yet reached the last MEM stage; from
    // there its data is forwarded from WB in the consumer's EXE cycle.
    function automatic logic [SEL_W+1:0] probe(input logic [NST-1:0] p,
                                               input logic [NST-1:0] l);
        logic             hit;
        logic             ld;
        logic [SEL_W-1:0] sel;
        hit = 1'b0;
        ld  = 1'b0;
        sel = '0;
        for (int k = MEM_LAT; k >= 0; k--) begin
            if (p[k]) begin
                hit = 1'b1;
                ld  = l[k] && (k < MEM_LAT);
                sel = SEL_W'(k + 1);
            end
        end
        return {hit, ld, sel};
    endfunction

    always_comb begin
        rel1 = id_valid && (id_src1 != '0);
        rel2 = id_valid && (id_src2 != '0) && (id_two_regs || id_src2_st);

        {hit1, ld1, sel1} = probe(pend_q[id_src1], load_q[id_src1]);
        {hit2, ld2, sel2} = probe(pend_q[id_src2], load_q[id_src2]);

        stall1 = rel1 && (en_fwd ? ld1 : hit1);
        stall2 = rel2 && (en_fwd ? ld2 : hit2);

        // Gated by reset so the freeze drops the moment reset asserts, and by
        // flush because the ID instruction is being killed anyway.
        hazard_detected = reset && !flush && (stall1 || stall2);
        issue           = id_valid && !hazard_detected && !flush;
    end

    // Scoreboard next state: shift every entry one stage older. A flush kills the
    // EXE-stage writer before it moves on and blocks the ID instruction from entering.
    always_comb begin
        pend_d = '0;
        load_d = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = {pend_q[r][NST-2:1], pend_q[r][0] & ~flush, 1'b0};
            load_d[r] = {load_q[r][NST-2:1], load_q[r][0] & ~flush, 1'b0};
        end
        if (issue && id_wb_en && (id_dest != '0)) begin
            pend_d[id_dest][0] = 1'b1;
            load_d[id_dest][0] = id_mem_read;
        end
    end

    // Selectors point at where the youngest writer will be one edge later, i.e.
    // in the consumer's EXE cycle; anything not issuing with forwarding gets 0.
    always_comb begin
        val1_d = '0;
        val2_d = '0;
        sv_d   = '0;
        if (issue && en_fwd) begin
            if (rel1)                val1_d = sel1;
            if (rel2 && id_two_regs) val2_d = sel2;
            if (rel2 && id_src2_st)  sv_d   = sel2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            load_q <= '0;
            val1_q <= '0;
            val2_q <= '0;
            sv_q   <= '0;
        end else begin
            pend_q <= pend_d;
            load_q <= load_d;
            val1_q <= val1_d;
            val2_q <= val2_d;
            sv_q   <= sv_d;
        end
    end

    assign val1_selector     = val1_q;
    assign val2_selector     = val2_q;
    assign src2_val_selector = sv_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic        lu_evt;

    // In forwarding mode the only stall source is the load rule.
    always_comb begin
        lu_evt      = hazard_detected && en_fwd && ((rel1 && ld1) || (rel2 && ld2));
        stall_cnt_d = stall_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        if (hazard_detected && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (lu_evt && (lu_cnt_q != 32'hFFFF_FFFF))             lu_cnt_d    = lu_cnt_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign stall_cycles    = stall_cnt_q;
    assign load_use_stalls = lu_cnt_q;
`endif

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the fixed 5-stage hazard-detection and forwarding pair. Tracks in-flight register writes in a per-register stage scoreboard.
- Supports a configurable number of MEM stages (multi-cycle data memory) and configurable register-file size.
- Sits between ID and the ID/EXE register. Drives the ID-stage freeze and the registered EXE-stage operand-forwarding selectors.

Parameters:
- REG_ADDR_W, 5, register address width; the register file has 2**REG_ADDR_W entries and r0 is hardwired to zero.
- MEM_LAT, 1, number of MEM pipeline stages (1..4). Stage indices: 0=EXE, 1..MEM_LAT=MEM1..MEMn, MEM_LAT+1=WB.
- SEL_W, $clog2(MEM_LAT+2), width of the forwarding selectors.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en_fwd  in  1  1 = forwarding enabled, 0 = stall-only mode.
- flush  in  1  branch taken in EXE; kills the instructions in ID and EXE this cycle.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_ADDR_W  first source register.
- id_src2  in  REG_ADDR_W  second source register, also used as store data.
- id_two_regs  in  1  src2 is read as an ALU operand.
- id_src2_st  in  1  src2 is read as store data.
- id_dest  in  REG_ADDR_W  destination register.
- id_wb_en  in  1  instruction writes id_dest.
- id_mem_read  in  1  instruction is a load.
- hazard_detected  out  1  combinational freeze for PC and IF/ID; ID/EXE takes a bubble.
- val1_selector  out  SEL_W  registered; forwarding source for EXE operand 1.
- val2_selector  out  SEL_W  registered; forwarding source for EXE ALU operand 2.
- src2_val_selector  out  SEL_W  registered; forwarding source for EXE store data.

Behaviour:
- Per-register state: pend[r] and load[r], each MEM_LAT+2 bits. Bit j set = a writer of r is at stage j.
- issue = id_valid & ~hazard_detected & ~flush.
- Every rising edge:
  - pend and load shift up by one; bit MEM_LAT+1 falls off.
  - If flush, bit 0 of every entry is cleared before the shift.
  - If issue & id_wb_en & id_dest!=0, bit 0 of pend[id_dest] is set, and bit 0 of load[id_dest] is set to id_mem_read.
- Source relevance:
  - src1 is relevant when id_valid and id_src1!=0.
  - src2 is relevant when id_valid, id_src2!=0, and (id_two_regs or id_src2_st).
  - Register 0 never hazards.
- For each relevant source s, j = lowest set bit of pend[s] in range 0..MEM_LAT (youngest writer wins). The WB bit is ignored because the register file is write-before-read.
- Stall rules:
  - en_fwd=0: stall if any pend[s] bit in 0..MEM_LAT is set.
  - en_fwd=1: stall only if load[s][j] is set and j<MEM_LAT (load data exists only at WB). ALU results never stall.
- hazard_detected = OR over relevant sources of the stall rule. Forced to 0 while flush=1.
- Selector register update on each edge:
  - If issue & en_fwd: each selector = j+1 when a writer is found (j+1 ≤ MEM_LAT+1), else 0.
  - Otherwise (stall, flush, bubble, en_fwd=0): each selector = 0.
- Selector encoding: 0 = ID/EXE register value; k = result register of stage k (1..MEM_LAT = MEMk output, MEM_LAT+1 = WB data).
- Latency: selectors are valid in the cycle the consumer occupies EXE, one edge after issue.
- Reset (asynchronous, any time, including mid-stall): all pend/load bits are cleared and all selectors go to 0. hazard_detected is 0 while reset=0.
- Simultaneous issue and flush: flush wins and the entry is not set.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined:
  - Adds output stall_cycles (32 bits), a saturating count of cycles with hazard_detected=1.
  - Adds output load_use_stalls (32 bits), counting stalls caused by the load rule.
  - Both counters clear on reset and hold at 32'hFFFFFFFF.
- Without the macro: these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- MEM_LAT=1, en_fwd=1: ADD writes r3, next instruction reads r3 as src1 -> hazard_detected=0 and val1_selector=1 in the consumer's EXE cycle. With one unrelated instruction between them -> val1_selector=2.
- MEM_LAT=1, en_fwd=1: LW writes r4, next instruction reads r4 as src2 with two_regs=1 -> exactly 1 stall cycle, then val2_selector=2.
- MEM_LAT=1, en_fwd=0: ADD writes r5, next instruction reads r5 -> 2 stall cycles, then all selectors=0.
- ADD writes r6 and is flushed while in EXE (flush=1); next instruction reads r6 -> no stall, selectors=0. Separately, ADD r7 followed by SUB r7 followed by a reader of r7 -> val1_selector=1 (youngest wins).
- MEM_LAT=3, en_fwd=1: LW writes r8, next instruction reads r8 -> 3 stall cycles, then val1_selector=4. A store using r8 as data gets src2_val_selector=4.
- Assert reset=0 during a load-use stall -> hazard_detected=0 immediately and selectors=0. After release, the old load is not tracked and the reader of r8 issues without a stall.
